// File: rtl/wisc_cpu.sv
// Single-cycle 16-bit WISC core: 16x16 register file, Z/V/N flags, internal instruction
// and data memories. Exposes only the current PC and a halt indicator.
module wisc_cpu #(
  parameter string       IMEM_FILE = "instructions.img",
  parameter string       DMEM_FILE = "data.img",
  parameter int unsigned MEM_AW    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  output logic        hlt
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0, OpSub  = 4'h1, OpXor = 4'h2, OpRed = 4'h3,
    OpSll  = 4'h4, OpSra  = 4'h5, OpRor = 4'h6, OpPad = 4'h7,
    OpLw   = 4'h8, OpSw   = 4'h9, OpLlb = 4'hA, OpLhb = 4'hB,
    OpB    = 4'hC, OpBr   = 4'hD, OpPcs = 4'hE, OpHlt = 4'hF
  } op_e;

  logic [15:0] r_imem [Depth];
  logic [15:0] r_dmem [Depth];

  logic [15:0] r_pc;
  logic [15:0] r_rf [16];
  logic        r_z, r_v, r_n;

  logic [15:0] w_instr;
  op_e         w_op;
  logic [3:0]  w_rd, w_rs, w_rt;
  logic [15:0] w_a, register2, w_pc_inc, w_pc_next;
  logic [15:0] alu_out, mem_out, output_value;
  logic        regwrite, memread, memwrite, w_taken;
  logic [3:0]  writereg;
  logic [16:0] w_sum;
  logic        w_ovf;
  logic [8:0]  w_red_hi, w_red_lo;
  logic [9:0]  w_red;
  logic [4:0]  w_nib;
  logic [15:0] w_pad;

  if (1'b1) begin : fetch0
    logic [15:0] instruction;
    assign instruction = r_imem[r_pc[MEM_AW:1]];
    assign w_instr     = instruction;
  end

  assign w_op = op_e'(w_instr[15:12]);
  assign w_rd = w_instr[11:8];
  assign w_rs = w_instr[7:4];
  assign w_rt = w_instr[3:0];

  // SW stores the rd field; LLB/LHB merge into the old rd value.
  assign w_a       = r_rf[w_rs];
  assign register2 = (w_op == OpSw || w_op == OpLlb || w_op == OpLhb) ? r_rf[w_rd] : r_rf[w_rt];
  assign w_pc_inc  = r_pc + 16'd2;

  assign w_sum = (w_op == OpSub) ? {w_a[15], w_a} - {register2[15], register2}
                                 : {w_a[15], w_a} + {register2[15], register2};
  assign w_ovf = w_sum[16] ^ w_sum[15];

  assign w_red_hi = {w_a[15], w_a[15:8]} + {register2[15], register2[15:8]};
  assign w_red_lo = {w_a[7], w_a[7:0]} + {register2[7], register2[7:0]};
  assign w_red    = {w_red_hi[8], w_red_hi} + {w_red_lo[8], w_red_lo};

  always_comb begin
    w_nib = '0;
    w_pad = '0;
    for (int i = 0; i < 4; i++) begin
      w_nib = {w_a[4*i+3], w_a[4*i+:4]} + {register2[4*i+3], register2[4*i+:4]};
      w_pad[4*i+:4] = (w_nib[4] ^ w_nib[3]) ? (w_nib[4] ? 4'h8 : 4'h7) : w_nib[3:0];
    end
  end

  always_comb begin
    alu_out = '0;
    case (w_op)
      OpAdd, OpSub: alu_out = w_ovf ? (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];
      OpXor:        alu_out = w_a ^ register2;
      OpRed:        alu_out = {{6{w_red[9]}}, w_red};
      OpSll:        alu_out = w_a << w_rt;
      OpSra:        alu_out = $signed(w_a) >>> w_rt;
      OpRor:        alu_out = (w_a >> w_rt) | (w_a << (5'd16 - {1'b0, w_rt}));
      OpPad:        alu_out = w_pad;
      OpLw, OpSw:   alu_out = {w_a[15:1], 1'b0} + {{11{w_rt[3]}}, w_rt, 1'b0};
      OpLlb:        alu_out = {register2[15:8], w_instr[7:0]};
      OpLhb:        alu_out = {w_instr[7:0], register2[7:0]};
      default:      alu_out = '0;
    endcase
  end

  assign mem_out  = r_dmem[alu_out[MEM_AW:1]];
  assign memread  = (w_op == OpLw);
  assign memwrite = (w_op == OpSw);
  assign regwrite = (w_instr[15] == 1'b0) || w_op == OpLw || w_op == OpLlb
                    || w_op == OpLhb || w_op == OpPcs;
  assign writereg = w_rd;
  assign output_value = (w_op == OpLw) ? mem_out : (w_op == OpPcs) ? w_pc_inc : alu_out;

  always_comb begin
    w_taken = 1'b0;
    case (w_instr[11:9])
      3'b000:  w_taken = ~r_z;
      3'b001:  w_taken = r_z;
      3'b010:  w_taken = ~r_z & ~r_n;
      3'b011:  w_taken = r_n;
      3'b100:  w_taken = r_z | ~r_n;
      3'b101:  w_taken = r_n | r_z;
      3'b110:  w_taken = r_v;
      default: w_taken = 1'b1;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_op == OpHlt)               w_pc_next = r_pc;
    else if (w_op == OpB && w_taken) w_pc_next = w_pc_inc + {{6{w_instr[8]}}, w_instr[8:0], 1'b0};
    else if (w_op == OpBr && w_taken) w_pc_next = w_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_z  <= 1'b0;
      r_v  <= 1'b0;
      r_n  <= 1'b0;
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      // R0 is hard-wired to zero by never accepting writes.
      if (regwrite && writereg != 4'd0) r_rf[writereg] <= output_value;
      if (w_instr[15] == 1'b0) r_z <= (alu_out == 16'h0000);
      if (w_op == OpAdd || w_op == OpSub) begin
        r_n <= alu_out[15];
        r_v <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (memwrite && rst_n) r_dmem[alu_out[MEM_AW:1]] <= register2;
  end

  assign pc  = r_pc;
  assign hlt = rst_n & (w_op == OpHlt);

endmodule

// File: tb/tb_wisc_cpu.sv
// Directed bench for wisc_cpu: two hand-assembled programs loaded straight into the
// instruction memory, with architectural state and trace nets checked each step.
module tb_wisc_cpu;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        hlt;

  int n_vec  = 0;
  int n_fail = 0;

  wisc_cpu #(
    .IMEM_FILE(""),
    .DMEM_FILE(""),
    .MEM_AW   (15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pc   (pc),
    .hlt  (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] prog1 [25] = '{
    16'hA134, 16'hB112, 16'hB401, 16'h9142, 16'h8542, 16'h1011, 16'hA201, 16'hC005,
    16'hC203, 16'hF000, 16'hF000, 16'hF000, 16'hA1FF, 16'hB17F, 16'h0312, 16'h2812,
    16'hE600, 16'hC203, 16'h1011, 16'hDE60, 16'hF000, 16'hB980, 16'h1A92, 16'h5B94,
    16'hF000
  };

  logic [15:0] prog2 [19] = '{
    16'hA17F, 16'hB180, 16'hA27F, 16'hB280, 16'h3312, 16'h7412, 16'h6514, 16'h4611,
    16'h571F, 16'h0011, 16'h936F, 16'h896F, 16'h2A93, 16'hC601, 16'hF000, 16'hABFE,
    16'hBBFF, 16'hDEB0, 16'hF000
  };

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 25; i++) dut.r_imem[i] = prog1[i];
    #1;
    check("reset_pc", pc, 16'h0000);
    check("reset_hlt", {15'd0, hlt}, 16'h0000);
    check("reset_flags", {13'd0, dut.r_z, dut.r_v, dut.r_n}, 16'h0000);
    check("reset_r1", dut.r_rf[1], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Program 1
    check("fetch_instr", dut.fetch0.instruction, 16'hA134);
    check("llb_regwrite", {15'd0, dut.regwrite}, 16'h0001);
    check("llb_writereg", {12'd0, dut.writereg}, 16'h0001);
    check("llb_outval", dut.output_value, 16'h0034);
    tick();
    check("lhb_outval", dut.output_value, 16'h1234);
    tick();
    check("r1_1234", dut.r_rf[1], 16'h1234);
    tick();
    check("sw_pc", pc, 16'h0006);
    check("sw_memwrite", {15'd0, dut.memwrite}, 16'h0001);
    check("sw_addr", dut.alu_out, 16'h0104);
    check("sw_data", dut.register2, 16'h1234);
    tick();
    check("dmem_0104", dut.r_dmem[15'h0082], 16'h1234);
    check("lw_memread", {15'd0, dut.memread}, 16'h0001);
    check("lw_addr", dut.alu_out, 16'h0104);
    check("lw_memout", dut.mem_out, 16'h1234);
    tick();
    check("r5_load", dut.r_rf[5], 16'h1234);
    tick();
    check("sub_zero_z", {15'd0, dut.r_z}, 16'h0001);
    check("r0_zero", dut.r_rf[0], 16'h0000);
    tick();
    tick();
    check("bne_not_taken", pc, 16'h0010);
    tick();
    check("beq_taken", pc, 16'h0018);
    tick();
    tick();
    check("r1_7fff", dut.r_rf[1], 16'h7FFF);
    tick();
    check("add_sat", dut.r_rf[3], 16'h7FFF);
    check("add_v", {15'd0, dut.r_v}, 16'h0001);
    check("add_n", {15'd0, dut.r_n}, 16'h0000);
    tick();
    check("xor_res", dut.r_rf[8], 16'h7FFE);
    check("xor_v_hold", {15'd0, dut.r_v}, 16'h0001);
    check("xor_z", {15'd0, dut.r_z}, 16'h0000);
    check("pcs_pc", pc, 16'h0020);
    tick();
    check("pcs_r6", dut.r_rf[6], 16'h0022);
    tick();
    check("beq_fallthru", pc, 16'h0024);
    tick();
    tick();
    check("br_always", pc, 16'h0022);
    tick();
    check("beq_second", pc, 16'h002A);
    tick();
    tick();
    check("sub_sat", dut.r_rf[10], 16'h8000);
    check("sub_v", {15'd0, dut.r_v}, 16'h0001);
    check("sub_n", {15'd0, dut.r_n}, 16'h0001);
    tick();
    check("sra_res", dut.r_rf[11], 16'hF800);
    check("hlt_pc", pc, 16'h0030);
    check("hlt_on", {15'd0, hlt}, 16'h0001);
    tick();
    tick();
    check("hlt_frozen_pc", pc, 16'h0030);
    check("hlt_frozen_r11", dut.r_rf[11], 16'hF800);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 16'h0000);
    check("async_rst_hlt", {15'd0, hlt}, 16'h0000);

    // Program 2
    for (int i = 0; i < 19; i++) dut.r_imem[i] = prog2[i];
    dut.r_imem[15'h7FFF] = 16'hCE12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("p2_r1", dut.r_rf[1], 16'h807F);
    tick();
    check("red_res", dut.r_rf[3], 16'hFFFE);
    tick();
    check("paddsb_res", dut.r_rf[4], 16'h807E);
    tick();
    check("ror_res", dut.r_rf[5], 16'hF807);
    tick();
    check("sll_res", dut.r_rf[6], 16'h00FE);
    tick();
    check("sra15_res", dut.r_rf[7], 16'hFFFF);
    check("add_r0_writereg", {12'd0, dut.writereg}, 16'h0000);
    check("add_r0_outval", dut.output_value, 16'h8000);
    tick();
    check("add_r0_discard", dut.r_rf[0], 16'h0000);
    check("add_neg_v", {15'd0, dut.r_v}, 16'h0001);
    check("add_neg_n", {15'd0, dut.r_n}, 16'h0001);
    check("sw_neg_addr", dut.alu_out, 16'h00FC);
    tick();
    check("lw_neg_memout", dut.mem_out, 16'hFFFE);
    tick();
    check("lw_neg_r9", dut.r_rf[9], 16'hFFFE);
    tick();
    check("xor_zero_z", {15'd0, dut.r_z}, 16'h0001);
    check("xor_n_hold", {15'd0, dut.r_n}, 16'h0001);
    tick();
    check("blt_taken", pc, 16'h001E);
    tick();
    tick();
    check("r11_fffe", dut.r_rf[11], 16'hFFFE);
    tick();
    check("br_to_top", pc, 16'hFFFE);
    tick();
    check("pc_wrap", pc, 16'h0024);
    check("hlt2_on", {15'd0, hlt}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
